// File: rtl/sym_pkg.sv
// sym_pkg: state encodings and link symbol constants shared by the symbol-link transmitter and receiver
package sym_pkg;
    localparam int STATE_W = 3;
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHK   = 3'd3,
        ST_STOP  = 3'd4
    } state_t;
    localparam logic [1:0] SYM_IDLE  = 2'b00;
    localparam logic [1:0] SYM_START = 2'b10;
    localparam logic [1:0] SYM_STOP  = 2'b01;
endpackage

// File: rtl/sym_shifter.sv
// sym_shifter: payload shift register with symbol down-counter and XOR checksum accumulator
module sym_shifter #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic [1:0]        head,
    output logic [1:0]        chk,
    output logic              last
);
    localparam int CW = (DATA_W / 2 > 1) ? $clog2(DATA_W / 2) : 1;
    logic [DATA_W-1:0] shreg;
    logic [CW-1:0]     cnt;
    assign head = shreg[DATA_W-1 -: 2];
    assign last = cnt == '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            chk   <= 2'b00;
            cnt   <= '0;
        end else if (load) begin
            shreg <= din;
            chk   <= 2'b00;
            cnt   <= CW'(DATA_W / 2 - 1);
        end else if (shift) begin
            shreg <= shreg << 2;
            chk   <= chk ^ head;
            cnt   <= cnt - CW'(1);
        end
    end
endmodule

// File: rtl/sym_frame_tx.sv
// sym_frame_tx: frames a handshaked payload word into START, MSB-first data symbols, XOR checksum, STOP
module sym_frame_tx
    import sym_pkg::*;
#(
    parameter int         DATA_W    = 8,
    parameter logic [1:0] IDLE_SYM  = SYM_IDLE,
    parameter logic [1:0] START_SYM = SYM_START,
    parameter logic [1:0] STOP_SYM  = SYM_STOP
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [1:0]         sym,
    output logic               sym_valid,
    input  logic               sym_ready,
    output logic               busy,
    output logic [STATE_W-1:0] state
);
    state_t     cur, nxt;
    logic       load, shift, last;
    logic [1:0] head, chk;
    sym_shifter #(.DATA_W(DATA_W)) u_shift (
        .clk(clk), .rst(rst), .load(load), .shift(shift), .din(in_data),
        .head(head), .chk(chk), .last(last)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cur <= ST_IDLE;
        else     cur <= nxt;
    end
    always_comb begin
        nxt   = cur;
        load  = 1'b0;
        shift = 1'b0;
        case (cur)
            ST_IDLE:  if (in_valid) begin
                nxt  = ST_START;
                load = 1'b1;
            end
            ST_START: if (sym_ready) nxt = ST_DATA;
            ST_DATA:  if (sym_ready) begin
                shift = 1'b1;
                if (last) nxt = ST_CHK;
            end
            ST_CHK:   if (sym_ready) nxt = ST_STOP;
            ST_STOP:  if (sym_ready) nxt = ST_IDLE;
            default:  nxt = ST_IDLE;
        endcase
    end
    // Outputs decode from registered state only; unreachable encodings look idle but never accept
    assign state     = cur;
    assign in_ready  = cur == ST_IDLE;
    assign busy      = cur != ST_IDLE;
    assign sym_valid = cur inside {ST_START, ST_DATA, ST_CHK, ST_STOP};
    assign sym       = cur == ST_START ? START_SYM :
                       cur == ST_DATA  ? head :
                       cur == ST_CHK   ? chk :
                       cur == ST_STOP  ? STOP_SYM : IDLE_SYM;
endmodule

// File: tb/tb_sym_frame_tx.sv
// tb_sym_frame_tx: directed vector table, corner sequences and randomized frames against a frame model
module tb_sym_frame_tx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] sym;
    logic       sym_valid;
    logic       sym_ready = 1'b1;
    logic       busy;
    logic [2:0] state;
    int checks = 0;
    int errors = 0;

    sym_frame_tx #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sym(sym), .sym_valid(sym_valid), .sym_ready(sym_ready), .busy(busy), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  d;
        int          sat;
        int          slen;
        logic [13:0] e;
    } vec_t;
    vec_t tbl[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame as 7 symbols packed MSB-first: START, data pairs high to low, XOR of pairs, STOP
    function automatic logic [13:0] frame_of(input logic [7:0] d);
        logic [13:0] f;
        logic [1:0]  x = 2'b00;
        logic [1:0]  s;
        f[13:12] = 2'b10;
        for (int i = 0; i < 4; i++) begin
            s = 2'((d >> (6 - 2 * i)) % 4);
            f[11 - 2 * i -: 2] = s;
            x = x ^ s;
        end
        f[3:2] = x;
        f[1:0] = 2'b01;
        return f;
    endfunction

    function automatic logic [2:0] state_at(input int i);
        return i == 0 ? 3'd1 : i <= 4 ? 3'd2 : i == 5 ? 3'd3 : 3'd4;
    endfunction

    task automatic check_idle(input string tag);
        check({tag, " in_ready"}, in_ready, 1);
        check({tag, " sym_valid"}, sym_valid, 0);
        check({tag, " sym"}, sym, 2'b00);
        check({tag, " state"}, state, 0);
        check({tag, " busy"}, busy, 0);
    endtask

    // Entered and left at a negedge with the DUT idle; stalls slen cycles on symbol index sat
    task automatic run_frame(input logic [7:0] d, input int sat, input int slen,
                             input logic [13:0] e, input logic [7:0] nd, input bit keep);
        check_idle("pre");
        in_data = d;
        in_valid = 1'b1;
        sym_ready = 1'b1;
        @(negedge clk);
        in_data = nd;
        in_valid = keep;
        for (int i = 0; i < 7; i++) begin
            for (int s = 0; s < ((i == sat) ? slen : 0); s++) begin
                sym_ready = 1'b0;
                check($sformatf("hold sym%0d", i), sym, e[13 - 2 * i -: 2]);
                check("hold valid", sym_valid, 1);
                check("hold state", state, state_at(i));
                @(negedge clk);
            end
            sym_ready = 1'b1;
            check($sformatf("sym%0d of %02h", i, d), sym, e[13 - 2 * i -: 2]);
            check("sym_valid", sym_valid, 1);
            check("state", state, state_at(i));
            check("in_ready busy", in_ready, 0);
            check("busy", busy, 1);
            @(negedge clk);
        end
        check("post state", state, 0);
        check("post in_ready", in_ready, 1);
    endtask

    initial begin
        int hits;
        int guard;
        tbl[0] = '{8'hC5, -1, 0, 14'b10_11_00_01_01_11_01};
        tbl[1] = '{8'hB4,  2, 3, 14'b10_10_11_01_00_00_01};
        tbl[2] = '{8'hFF, -1, 0, 14'b10_11_11_11_11_00_01};
        tbl[3] = '{8'h1E, -1, 0, 14'b10_00_01_11_10_00_01};
        #1;
        check_idle("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("after reset");

        // C5 with FF offered throughout; FF must wait for the idle cycle
        run_frame(tbl[0].d, tbl[0].sat, tbl[0].slen, tbl[0].e, 8'hFF, 1'b1);
        run_frame(tbl[2].d, tbl[2].sat, tbl[2].slen, tbl[2].e, 8'h00, 1'b0);
        for (int k = 0; k < 4; k++) begin
            run_frame(tbl[k].d, tbl[k].sat, tbl[k].slen, tbl[k].e, 8'h00, 1'b0);
            check("table vs model", frame_of(tbl[k].d), tbl[k].e);
        end

        // Asynchronous reset mid-DATA, after two data symbols consumed
        in_data = 8'h5A;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-abort state", state, 2);
        #2 rst = 1'b1;
        #1 check_idle("async abort");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_idle("after abort");
        run_frame(tbl[3].d, tbl[3].sat, tbl[3].slen, tbl[3].e, 8'h00, 1'b0);

        // Continuous in_valid: exactly one acceptance every 8 cycles
        hits = 0;
        in_valid = 1'b1;
        in_data = 8'h96;
        for (int c = 0; c < 32; c++) begin
            if (in_ready) hits++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("continuous in_ready count", hits, 4);
        guard = 0;
        while (busy && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("drain timeout", busy, 0);

        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            d = 8'($urandom);
            run_frame(d, int'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                      frame_of(d), 8'($urandom), 1'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
